ccg_sweep_harness: RTL

- Sequential counterpart to the generated combinational CCGRCG netlists: it drives every input vector x[N_IN-1:0] into the circuit, settles, and samples outputs f[N_OUT-1:0].
- It streams each truth-table row out over a valid/ready port and compacts all rows into a MISR signature.
- It sits between the dataset's generated combinational block and the label/checker logic. It is the reader of the netlist's outputs.

---
 rtl/ccg_sweep_pkg.sv | 29 ++
 rtl/ccg_misr.sv | 28 ++
 rtl/ccg_sweep_harness.sv | 108 ++++++++++
 3 files changed

// File: rtl/ccg_sweep_pkg.sv
// Shared types and MISR arithmetic for the truth-table sweep harness.
// The MISR step is width-generic (up to 32 bits) so the harness and any model agree.
package ccg_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } sweep_state_t;

    localparam logic [15:0] SIG_POLY_DEFAULT = 16'h1021;
    localparam logic [15:0] SIG_SEED_DEFAULT = 16'h0000;

    // Galois-style shift with feedback from the MSB, then fold in the row data.
    function automatic logic [31:0] misr_step(
        input logic [31:0] sig,
        input logic [31:0] data,
        input logic [31:0] poly,
        input int          width
    );
        logic [31:0] mask;
        logic [31:0] nxt;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        nxt  = (sig << 1) ^ (sig[5'(width - 1)] ? poly : 32'd0) ^ data;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register compacting one sampled row per enable.
// A load restarts compaction from the supplied seed.
module ccg_misr
    import ccg_sweep_pkg::*;
#(
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= seed;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= SIG_W'(misr_step(32'(sig), 32'(data), 32'(SIG_POLY), SIG_W));
        end
    end

endmodule

// File: rtl/ccg_sweep_harness.sv
// Sweeps every input vector through a combinational netlist, streams each
// sampled row over valid/ready and compacts all rows into a MISR signature.
module ccg_sweep_harness
    import ccg_sweep_pkg::*;
#(
    parameter int               N_IN          = 7,
    parameter int               N_OUT         = 5,
    parameter int               SETTLE_CYCLES = 2,
    parameter int               SIG_W         = 16,
    parameter logic [SIG_W-1:0] SIG_POLY      = SIG_POLY_DEFAULT,
    parameter logic [SIG_W-1:0] SIG_SEED      = SIG_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  x_out,
    input  logic [N_OUT-1:0] f_in,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [N_IN-1:0]  row_index,
    output logic [N_OUT-1:0] row_data,
    output logic [SIG_W-1:0] signature
);

    localparam logic [1:0]      ST_IDLE     = IDLE;
    localparam logic [1:0]      ST_DRIVE    = DRIVE;
    localparam logic [1:0]      ST_CAPTURE  = CAPTURE;
    localparam logic [1:0]      ST_DONE     = DONE;
    localparam logic [N_IN-1:0] LAST_IDX    = '1;
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [N_IN-1:0]  idx;
    logic [7:0]       settle;
    logic             accept_start;
    logic             handshake;
    logic [SIG_W-1:0] misr_data;

    assign accept_start = (state == ST_IDLE) && start;
    assign handshake    = (state == ST_CAPTURE) && row_ready;
    assign busy         = (state == ST_DRIVE) || (state == ST_CAPTURE);
    assign done         = (state == ST_DONE);
    assign row_valid    = (state == ST_CAPTURE);
    assign misr_data    = SIG_W'(row_data);

    // f_in is only trusted on the last settle cycle; x_out holds through any stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            settle    <= '0;
            x_out     <= '0;
            row_index <= '0;
            row_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        x_out  <= '0;
                        settle <= '0;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle == SETTLE_LAST) begin
                        row_data  <= f_in;
                        row_index <= idx;
                        state     <= ST_CAPTURE;
                    end else begin
                        settle <= settle + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (row_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx    <= idx + 1'b1;
                            x_out  <= idx + 1'b1;
                            settle <= '0;
                            state  <= ST_DRIVE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ccg_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_start),
        .seed  (SIG_SEED),
        .en    (handshake),
        .data  (misr_data),
        .sig   (signature)
    );

endmodule
